mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters of the pipelined RV64I datapath: instruction fetch (IF, read-only) and the MEM stage (DM, read/write).
- Only one transaction is outstanding at a time.
- Requests use a level-held req / one-cycle ack handshake.
- Generates the IF and DM stall signals that freeze the pipeline while a requester waits.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam int unsigned INSTR_W = 32;

    // Select one 32-bit instruction out of a 64-bit memory word.
    function automatic logic [INSTR_W-1:0] pick_instr(
        input logic [2*INSTR_W-1:0] word,
        input logic                 hi
    );
        return hi ? word[2*INSTR_W-1:INSTR_W] : word[INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage,
// one transaction in flight, with starvation protection for fetch and flush cancel.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_ack,
    output logic [INSTR_W-1:0]    if_rdata,
    output logic                  if_stall,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic                  dm_ack,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(7);

    state_t             state;
    owner_t             owner;
    logic               cancel;
    logic               if_word_hi;
    logic [CNT_W-1:0]   starve_cnt;

    logic               if_elig;
    logic               starve_hit;
    logic               grant_dm;
    logic               grant_if;
    logic               rsp_valid;

    // DM wins by default; a starved fetch takes the next slot.
    assign if_elig    = if_req & ~if_flush;
    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
    assign grant_dm   = dm_req & ~(if_elig & starve_hit);
    assign grant_if   = if_elig & ~grant_dm;

    // A completion in the issue cycle violates the memory contract and is dropped.
    assign rsp_valid  = mem_rvalid & ~mem_req;

    assign if_stall   = if_req & ~if_ack;
    assign dm_stall   = dm_req & ~dm_ack;

    // Counts DM grants that bypassed a waiting fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_if) begin
            starve_cnt <= '0;
        end else if (state == IDLE && grant_dm && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            cancel     <= 1'b0;
            if_word_hi <= 1'b0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_ack     <= 1'b0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            mem_req <= 1'b0;
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (grant_dm) begin
                        owner     <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_wstrb <= dm_wstrb;
                        state     <= WAIT;
                    end else if (grant_if) begin
                        owner      <= OWN_IF;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr & WORD_MASK;
                        mem_wdata  <= '0;
                        mem_wstrb  <= STRB_W'(0);
                        if_word_hi <= if_addr[2];
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner == OWN_IF && if_flush) begin
                        cancel <= 1'b1;
                    end
                    if (rsp_valid) begin
                        state <= RESP;
                        if (owner == OWN_DM) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= mem_we ? '0 : mem_rdata;
                        end else if (!cancel && !if_flush) begin
                            if_ack   <= 1'b1;
                            if_rdata <= pick_instr(mem_rdata[2*INSTR_W-1:0], if_word_hi);
                        end
                    end
                end
                RESP: begin
                    cancel <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Requesters hold req until their ack; only a flushed fetch may withdraw.
    a_dm_req_held: assert property (@(posedge clk) disable iff (rst)
        $fell(dm_req) |-> dm_ack)
        else $error("dm_req dropped before dm_ack");

    a_if_req_held: assert property (@(posedge clk) disable iff (rst)
        $fell(if_req) |-> (if_ack || if_flush))
        else $error("if_req dropped before if_ack without if_flush");

    a_one_ack: assert property (@(posedge clk) disable iff (rst)
        !(if_ack && dm_ack))
        else $error("if_ack and dm_ack asserted together");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-modelled memory, per-port response scoreboard,
// a vector table of solo transactions and directed reset/contention/starvation/flush runs.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, if_flush, if_ack, if_stall;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_stall;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic [7:0]  dm_wstrb;
    logic        mem_req, mem_we, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat    = 2;

    typedef struct {
        int          cyc;
        logic        we;
        logic [63:0] addr;
    } issue_t;
    issue_t issue_q[$];

    logic [63:0] mem_model [logic [63:0]];
    logic [63:0] if_exp_q[$];
    logic [63:0] dm_exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem_model.exists(a) ? mem_model[a] : 64'h0;
    endfunction

    // Memory: accepts mem_req, answers with mem_rvalid exactly lat cycles later.
    initial begin
        int          cnt_dn;
        logic [63:0] rsp;
        logic [63:0] w;
        cnt_dn     = 0;
        rsp        = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_rvalid = 1'b0;
            if (cnt_dn > 0) begin
                cnt_dn--;
                if (cnt_dn == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp;
                end
            end
            if (mem_req === 1'b1) begin
                issue_q.push_back('{cyc: cyc, we: mem_we, addr: mem_addr});
                if (mem_we) begin
                    w = rd(mem_addr);
                    for (int b = 0; b < 8; b++)
                        if (mem_wstrb[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    mem_model[mem_addr] = w;
                    rsp = 64'hDEAD_BEEF_DEAD_BEEF;
                end else begin
                    rsp = rd(mem_addr);
                end
                cnt_dn = lat;
            end
        end
    end

    // Scoreboard: every ack pops the oldest expectation of its port.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (if_ack === 1'b1) begin
                if (if_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL if_ack_unexpected: got if_ack=1 rdata %h, expected no ack", if_rdata);
                end else begin
                    check("if_rdata", {32'h0, if_rdata}, if_exp_q.pop_front());
                end
            end
            if (dm_ack === 1'b1) begin
                if (dm_exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL dm_ack_unexpected: got dm_ack=1 rdata %h, expected no ack", dm_rdata);
                end else begin
                    check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One request through the handshake; returns the raise and ack cycles.
    task automatic do_txn(input logic is_dm, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wstrb,
                          input logic [63:0] exp, output int t_req, output int t_ack);
        bit got;
        got   = 0;
        t_ack = -1;
        t_req = cyc;
        if (is_dm) begin
            dm_exp_q.push_back(exp);
            dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_wstrb = wstrb; dm_req = 1'b1;
        end else begin
            if_exp_q.push_back({32'h0, exp[31:0]});
            if_addr = addr; if_req = 1'b1;
        end
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            if (is_dm ? dm_ack : if_ack) begin
                got   = 1;
                t_ack = cyc;
                check(is_dm ? "dm_stall_at_ack" : "if_stall_at_ack",
                      64'(is_dm ? dm_stall : if_stall), 64'h0);
                if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
            end else begin
                check(is_dm ? "dm_stall_wait" : "if_stall_wait",
                      64'(is_dm ? dm_stall : if_stall), 64'h1);
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got no ack for addr %h, expected ack", is_dm ? "dm" : "if", addr);
            if (is_dm) begin dm_req = 1'b0; void'(dm_exp_q.pop_back()); end
            else begin if_req = 1'b0; void'(if_exp_q.pop_back()); end
        end
    endtask

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] exp;
        logic [63:0] exp_maddr;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   t0, t1, ta0, ta1, tb0, tb1, n0;
        logic [63:0] exp_addr[7];

        vecs[0] = '{0, 0, 64'h4,   64'h0, 8'h00, 64'h00B00213, 64'h0};
        vecs[1] = '{0, 0, 64'h0,   64'h0, 8'h00, 64'h00C00193, 64'h0};
        vecs[2] = '{1, 1, 64'h108, 64'h11223344_55667788, 8'h0F, 64'h0, 64'h108};
        vecs[3] = '{1, 0, 64'h108, 64'h0, 8'h00, 64'hAAAAAAAA_55667788, 64'h108};
        vecs[4] = '{0, 0, 64'h10C, 64'h0, 8'h00, 64'hAAAAAAAA, 64'h108};
        vecs[5] = '{0, 0, 64'h10A, 64'h0, 8'h00, 64'h55667788, 64'h108};
        vecs[6] = '{1, 1, 64'h110, 64'h01234567_89ABCDEF, 8'hF0, 64'h0, 64'h110};
        vecs[7] = '{1, 0, 64'h110, 64'h0, 8'h00, 64'h01234567_00000000, 64'h110};

        mem_model[64'h0]   = 64'h00B00213_00C00193;
        mem_model[64'h8]   = 64'h12345678_9ABCDEF0;
        mem_model[64'h20]  = 64'h77777777_66666666;
        mem_model[64'h40]  = 64'hCAFE0013_00000093;
        mem_model[64'h108] = 64'hAAAAAAAA_BBBBBBBB;
        for (int i = 0; i < 6; i++) mem_model[64'h200 + 64'(8*i)] = 64'h5000 + 64'(i);

        rst = 1'b1;
        if_req = 0; if_flush = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        repeat (3) tick();

        check("rst_mem_req",   64'(mem_req), 64'h0);
        check("rst_mem_addr",  mem_addr, 64'h0);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        check("rst_mem_we_strb", {55'h0, mem_we, mem_wstrb}, 64'h0);
        check("rst_acks",      {62'h0, if_ack, dm_ack}, 64'h0);
        check("rst_if_rdata",  {32'h0, if_rdata}, 64'h0);
        check("rst_dm_rdata",  dm_rdata, 64'h0);
        rst = 1'b0;
        tick();

        // Reset while a DM load waits on memory.
        lat = 5;
        dm_we = 0; dm_addr = 64'h100; dm_req = 1'b1;
        tick();
        check("rst_wait_issue", {63'h0, mem_req}, 64'h1);
        check("rst_wait_issue_addr", mem_addr, 64'h100);
        tick();
        rst = 1'b1; dm_req = 1'b0;
        #1;
        check("midrst_mem_req",  64'(mem_req), 64'h0);
        check("midrst_mem_addr", mem_addr, 64'h0);
        check("midrst_dm_ack",   64'(dm_ack), 64'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_dm_ack", 64'(dm_ack), 64'h0);
        end

        // Solo transactions, L=2: issue one cycle after req, ack at req+4.
        lat = 2;
        foreach (vecs[i]) begin
            tick();
            n0 = issue_q.size();
            do_txn(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                   vecs[i].exp, t0, t1);
            check($sformatf("vec%0d_issue_count", i), 64'(issue_q.size() - n0), 64'h1);
            if (issue_q.size() > n0) begin
                check($sformatf("vec%0d_mem_addr", i), issue_q[n0].addr, vecs[i].exp_maddr);
                check($sformatf("vec%0d_mem_we", i), 64'(issue_q[n0].we), 64'(vecs[i].we));
                check($sformatf("vec%0d_issue_cycle", i), 64'(issue_q[n0].cyc - t0), 64'h1);
            end
            check($sformatf("vec%0d_ack_cycle", i), 64'(t1 - t0), 64'h4);
        end

        // Contention: DM store and IF fetch raised together.
        lat = 3;
        tick();
        n0 = issue_q.size();
        fork
            do_txn(1'b1, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, ta0, ta1);
            do_txn(1'b0, 1'b0, 64'h4, 64'h0, 8'h00, 64'h00B00213, tb0, tb1);
        join
        check("cont_issue_count", 64'(issue_q.size() - n0), 64'h2);
        if (issue_q.size() >= n0 + 2) begin
            check("cont_first_dm",  {issue_q[n0].addr[62:0], issue_q[n0].we}, {63'h100, 1'b1});
            check("cont_second_if", {issue_q[n0+1].addr[62:0], issue_q[n0+1].we}, {63'h0, 1'b0});
        end
        check("cont_mem_word", rd(64'h100), 64'hFFFF_FFFF_FFFF_FFFF);

        // Load back the stored word; ack must last one cycle.
        tick();
        do_txn(1'b1, 1'b0, 64'h100, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, t0, t1);
        tick();
        check("dm_ack_one_cycle", 64'(dm_ack), 64'h0);

        // Starvation: IF held while DM issues six back-to-back loads.
        lat = 1;
        tick();
        n0 = issue_q.size();
        fork
            do_txn(1'b0, 1'b0, 64'h40, 64'h0, 8'h00, 64'h00000093, ta0, ta1);
            begin
                for (int i = 0; i < 6; i++)
                    do_txn(1'b1, 1'b0, 64'h200 + 64'(8*i), 64'h0, 8'h00, 64'h5000 + 64'(i), tb0, tb1);
            end
        join
        exp_addr = '{64'h200, 64'h208, 64'h210, 64'h218, 64'h40, 64'h220, 64'h228};
        check("starve_issue_count", 64'(issue_q.size() - n0), 64'h7);
        if (issue_q.size() >= n0 + 7)
            for (int i = 0; i < 7; i++)
                check($sformatf("starve_order%0d", i), issue_q[n0+i].addr, exp_addr[i]);

        // Flush an in-flight fetch, then fetch again.
        lat = 4;
        tick();
        if_addr = 64'h20; if_req = 1'b1;
        tick();
        check("flush_issue", {63'h0, mem_req}, 64'h1);
        tick();
        if_flush = 1'b1; if_req = 1'b0;
        tick();
        if_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("flush_no_if_ack", 64'(if_ack), 64'h0);
        end
        tick();
        do_txn(1'b0, 1'b0, 64'h8, 64'h0, 8'h00, 64'h9ABCDEF0, t0, t1);
        repeat (4) tick();

        check("if_exp_drained", 64'(if_exp_q.size()), 64'h0);
        check("dm_exp_drained", 64'(dm_exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
